// File: rtl/bcd_count_controller.sv
`default_nettype none
// ============================================================================
// Module      : bcd_count_controller
// Description : Command-driven sequencer for an internal DIGITS-wide BCD
//               counter. Accepts START/STOP/CLEAR/LOAD commands, validates
//               loaded terminal-count targets, and pulses done at terminal
//               count in one-shot or auto-reload mode.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_count_controller #(
    parameter int DIGITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*DIGITS-1:0] cmd_data,
    input  logic                mode_reload,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                done,
    output logic                bcd_err
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] c_op_start = 2'b00;
    localparam logic [1:0] c_op_stop  = 2'b01;
    localparam logic [1:0] c_op_clear = 2'b10;
    localparam logic [1:0] c_op_load  = 2'b11;

    localparam logic [W-1:0] c_all_nines = {DIGITS{4'd9}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HALT  = 3'd3,
        ST_CHECK = 3'd4
    } state_t;

    state_t         state_q, state_d;
    state_t         ret_state_q, ret_state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   target_q, target_d;
    logic [W-1:0]   staged_q, staged_d;
    logic           done_q, done_d;
    logic           bcd_err_q, bcd_err_d;

    logic           w_accept;
    logic           w_start, w_stop, w_clear, w_load;

    // Ripple-carry BCD increment; all-nines wraps to zero.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic         carry;
        logic [W-1:0] r;
        carry = 1'b1;
        r     = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every nibble is a legal BCD digit.
    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Commands are refused during reset and during the one-cycle target check.
    assign cmd_ready = reset && (state_q != ST_CHECK);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_start   = w_accept && (cmd_op == c_op_start);
    assign w_stop    = w_accept && (cmd_op == c_op_stop);
    assign w_clear   = w_accept && (cmd_op == c_op_clear);
    assign w_load    = w_accept && (cmd_op == c_op_load);

    assign count   = count_q;
    assign running = (state_q == ST_RUN);
    assign done    = done_q;
    assign bcd_err = bcd_err_q;

    // Next-state, counter and target update logic.
    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        count_d     = count_q;
        target_d    = target_q;
        staged_d    = staged_q;
        done_d      = 1'b0;
        bcd_err_d   = bcd_err_q;

        if (w_load) staged_d = cmd_data;

        unique case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_RUN;
                end else if (w_clear) begin
                    count_d = '0;
                end else if (w_load) begin
                    state_d     = ST_CHECK;
                    ret_state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // STOP and CLEAR take priority over terminal count; START
                // and LOAD are swallowed and counting carries on.
                if (w_stop) begin
                    state_d = ST_PAUSE;
                end else if (w_clear) begin
                    count_d = '0;
                end else if (count_q == target_q) begin
                    done_d = 1'b1;
                    if (mode_reload) begin
                        count_d = '0;
                    end else begin
                        state_d = ST_HALT;
                    end
                end else begin
                    count_d = bcd_inc(count_q);
                end
            end
            ST_PAUSE: begin
                if (w_start) begin
                    state_d = ST_RUN;
                end else if (w_clear) begin
                    count_d = '0;
                end else if (w_load) begin
                    state_d     = ST_CHECK;
                    ret_state_d = ST_PAUSE;
                end
            end
            ST_HALT: begin
                if (w_start) begin
                    count_d = '0;
                    state_d = ST_RUN;
                end else if (w_clear) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (w_stop) begin
                    state_d = ST_IDLE;
                end else if (w_load) begin
                    state_d     = ST_CHECK;
                    ret_state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                state_d = ret_state_q;
                if (bcd_valid(staged_q)) begin
                    target_d  = staged_q;
                    bcd_err_d = 1'b0;
                end else begin
                    bcd_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ret_state_q <= ST_IDLE;
            count_q     <= '0;
            target_q    <= c_all_nines;
            staged_q    <= '0;
            done_q      <= 1'b0;
            bcd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            count_q     <= count_d;
            target_q    <= target_d;
            staged_q    <= staged_d;
            done_q      <= done_d;
            bcd_err_q   <= bcd_err_d;
        end
    end

endmodule
`default_nettype wire
